multicycle_sequencer: RTL and testbench

Multi-cycle control sequencer that steps the processor datapath through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK for each 6-bit opcode. It drives the per-state control strobes of the datapath. It arbitrates the single memory port between instruction fetch and data access. It supervises memory handshakes with a timeout, and it counts retired instructions.

---
 rtl/multicycle_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// stepping with shared memory port, handshake timeout and retire counter.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [5:0]       alu_op,
  output logic             alu_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [2:0]       state,
  output logic             halted,
  output logic             bus_error,
  output logic [CNT_W-1:0] instr_count
);

  // Wait counter only needs to hold 0..TIMEOUT-1; timeout fires on the last value.
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_LOAD  = 6'b010000;
  localparam logic [5:0] OP_STORE = 6'b010001;
  localparam logic [5:0] OP_JUMP  = 6'b010010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic              r_halted;
  logic              r_bus_error;
  logic [CNT_W-1:0]  r_instr_count;

  logic w_is_alu, w_is_branch, w_is_load, w_is_store, w_is_jump, w_is_halt;
  logic w_retire, w_timeout;
  logic w_mem_req, w_mem_we, w_mem_addr_sel, w_ir_write, w_pc_write;
  logic w_alu_src, w_reg_write, w_mem_to_reg;
  logic [1:0] w_pc_src;
  logic [5:0] w_alu_op;

  // Opcode class decode; NOP and unlisted opcodes fall through to no class.
  always_comb begin
    w_is_alu    = 1'b0;
    w_is_branch = 1'b0;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_jump   = 1'b0;
    w_is_halt   = 1'b0;
    case (opcode)
      6'b000001, 6'b000111, 6'b000100, 6'b001010: w_is_alu    = 1'b1;
      6'b000011, 6'b000110, 6'b001001:            w_is_branch = 1'b1;
      OP_LOAD:                                    w_is_load   = 1'b1;
      OP_STORE:                                   w_is_store  = 1'b1;
      OP_JUMP:                                    w_is_jump   = 1'b1;
      OP_HALT:                                    w_is_halt   = 1'b1;
      OP_NOP:                                     ;
      default:                                    ;
    endcase
  end

  // Next-state and per-state control strobe decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr_sel = 1'b0;
    w_ir_write     = 1'b0;
    w_pc_write     = 1'b0;
    w_pc_src       = 2'b00;
    w_alu_op       = 6'd0;
    w_alu_src      = 1'b0;
    w_reg_write    = 1'b0;
    w_mem_to_reg   = 1'b0;
    w_retire       = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_write  = 1'b1;
          w_pc_write  = 1'b1;
          w_pc_src    = 2'b00;
          w_state_nxt = S_DECODE;
        end else if (r_wait == WAIT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_HALTED;
        end
      end
      S_DECODE: begin
        w_state_nxt = w_is_halt ? S_HALTED : S_EXECUTE;
      end
      S_EXECUTE: begin
        w_alu_op  = opcode;
        w_alu_src = w_is_alu | w_is_load | w_is_store;
        if (w_is_alu) begin
          w_state_nxt = S_WRITEBACK;
        end else if (w_is_load || w_is_store) begin
          w_state_nxt = S_MEMORY;
        end else begin
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
          if (w_is_branch && zero) begin
            w_pc_write = 1'b1;
            w_pc_src   = 2'b01;
          end else if (w_is_jump) begin
            w_pc_write = 1'b1;
            w_pc_src   = 2'b10;
          end
        end
      end
      S_MEMORY: begin
        w_mem_req      = 1'b1;
        w_mem_addr_sel = 1'b1;
        w_mem_we       = w_is_store;
        if (mem_ready) begin
          if (w_is_load) begin
            w_state_nxt = S_WRITEBACK;
          end else begin
            w_retire    = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_HALTED;
        end
      end
      S_WRITEBACK: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = w_is_load;
        w_retire     = 1'b1;
        w_state_nxt  = S_FETCH;
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  // Memory wait counter: counts stalled cycles, zero whenever not stalling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if ((r_state == S_FETCH || r_state == S_MEMORY) && !mem_ready && !w_timeout) begin
      r_wait <= r_wait + WAIT_W'(1);
    end else begin
      r_wait <= '0;
    end
  end

  // Status flags and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted      <= 1'b0;
      r_bus_error   <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_halted    <= (w_state_nxt == S_HALTED);
      r_bus_error <= r_bus_error | w_timeout;
      if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  // Strobes are forced low while reset is asserted.
  assign mem_req      = rst_n & w_mem_req;
  assign mem_we       = rst_n & w_mem_we;
  assign mem_addr_sel = rst_n & w_mem_addr_sel;
  assign ir_write     = rst_n & w_ir_write;
  assign pc_write     = rst_n & w_pc_write;
  assign pc_src       = rst_n ? w_pc_src : 2'b00;
  assign alu_op       = rst_n ? w_alu_op : 6'd0;
  assign alu_src      = rst_n & w_alu_src;
  assign reg_write    = rst_n & w_reg_write;
  assign mem_to_reg   = rst_n & w_mem_to_reg;

  assign state       = 3'(r_state);
  assign halted      = r_halted;
  assign bus_error   = r_bus_error;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed testbench for multicycle_sequencer (TIMEOUT=4, CNT_W=2).
module tb_multicycle_sequencer;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
  logic [1:0] pc_src;
  logic [5:0] alu_op;
  logic       alu_src, reg_write, mem_to_reg;
  logic [2:0] state;
  logic       halted, bus_error;
  logic [1:0] instr_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Strobe vector: {req, we, addr_sel, ir_w, pc_w, pc_src[1:0], alu_src, reg_w, mem_to_reg}
  localparam logic [9:0] SB_NONE  = 10'b0000000000;
  localparam logic [9:0] SB_FETCH = 10'b1001100000;
  localparam logic [9:0] SB_FWAIT = 10'b1000000000;
  localparam logic [9:0] SB_EXIMM = 10'b0000000100;
  localparam logic [9:0] SB_BRTKN = 10'b0000101000;
  localparam logic [9:0] SB_JUMP  = 10'b0000110000;
  localparam logic [9:0] SB_MEMRD = 10'b1010000000;
  localparam logic [9:0] SB_MEMWR = 10'b1110000000;
  localparam logic [9:0] SB_WBALU = 10'b0000000010;
  localparam logic [9:0] SB_WBLD  = 10'b0000000011;

  localparam logic [5:0] OP_ALU  = 6'b000001;
  localparam logic [5:0] OP_BR   = 6'b000011;
  localparam logic [5:0] OP_LD   = 6'b010000;
  localparam logic [5:0] OP_ST   = 6'b010001;
  localparam logic [5:0] OP_JMP  = 6'b010010;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_ILL  = 6'b101010;

  multicycle_sequencer #(.TIMEOUT(4), .CNT_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src(alu_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .state(state), .halted(halted), .bus_error(bus_error), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] strobes();
    return {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src, reg_write, mem_to_reg};
  endfunction

  // Hold reset for two cycles and release it on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = OP_ALU;
    @(negedge clk); #1;
    n_tests++;
    if (state !== 3'd0 || strobes() !== SB_NONE || alu_op !== 6'd0 || instr_count !== 2'd0 ||
        halted !== 1'b0 || bus_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: state=%0d strb=%b aluop=%b cnt=%0d halt=%b berr=%b want 0 all-zero",
               state, strobes(), alu_op, instr_count, halted, bus_error);
    end
    @(negedge clk);
    rst_n = 1'b1; #1;
    n_tests++;
    if (state !== 3'd0 || strobes() !== SB_FETCH) begin
      n_fail++;
      $display("FAIL reset_first_fetch: state=%0d strb=%b want 0 %b", state, strobes(), SB_FETCH);
    end
  endtask

  task automatic test_alu();
    logic [2:0] es [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    logic [9:0] ex [5] = '{SB_FETCH, SB_NONE, SB_EXIMM, SB_WBALU, SB_FETCH};
    logic [1:0] ec [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    opcode = OP_ALU;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1; #1;
      n_tests++;
      if (state !== es[i] || strobes() !== ex[i] || instr_count !== ec[i] ||
          alu_op !== ((es[i] == 3'd2) ? opcode : 6'd0)) begin
        n_fail++;
        $display("FAIL alu cyc%0d: state=%0d strb=%b aluop=%b cnt=%0d want %0d %b cnt=%0d",
                 i, state, strobes(), alu_op, instr_count, es[i], ex[i], ec[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_wait();
    logic       rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] es [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    logic [9:0] ex [8] = '{SB_FETCH, SB_NONE, SB_EXIMM, SB_MEMRD, SB_MEMRD, SB_MEMRD, SB_WBLD, SB_FETCH};
    logic [1:0] ec [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    opcode = OP_LD;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      mem_ready = rd[i]; #1;
      n_tests++;
      if (state !== es[i] || strobes() !== ex[i] || instr_count !== ec[i] ||
          alu_op !== ((es[i] == 3'd2) ? opcode : 6'd0)) begin
        n_fail++;
        $display("FAIL load cyc%0d: state=%0d strb=%b aluop=%b cnt=%0d want %0d %b cnt=%0d",
                 i, state, strobes(), alu_op, instr_count, es[i], ex[i], ec[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic       zr [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0] es [7] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
    logic [9:0] ex [7] = '{SB_FETCH, SB_NONE, SB_BRTKN, SB_FETCH, SB_NONE, SB_NONE, SB_FETCH};
    logic [1:0] ec [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    opcode = OP_BR;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      mem_ready = 1'b1; zero = zr[i]; #1;
      n_tests++;
      if (state !== es[i] || strobes() !== ex[i] || instr_count !== ec[i] ||
          alu_op !== ((es[i] == 3'd2) ? opcode : 6'd0)) begin
        n_fail++;
        $display("FAIL branch cyc%0d: state=%0d strb=%b cnt=%0d want %0d %b cnt=%0d",
                 i, state, strobes(), instr_count, es[i], ex[i], ec[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jump_illegal();
    logic [5:0] op [7] = '{OP_JMP, OP_JMP, OP_JMP, OP_ILL, OP_ILL, OP_ILL, OP_ILL};
    logic [2:0] es [7] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
    logic [9:0] ex [7] = '{SB_FETCH, SB_NONE, SB_JUMP, SB_FETCH, SB_NONE, SB_NONE, SB_FETCH};
    logic [1:0] ec [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    opcode = OP_JMP;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      mem_ready = 1'b1; opcode = op[i]; #1;
      n_tests++;
      if (state !== es[i] || strobes() !== ex[i] || instr_count !== ec[i] ||
          alu_op !== ((es[i] == 3'd2) ? op[i] : 6'd0)) begin
        n_fail++;
        $display("FAIL jump_ill cyc%0d: state=%0d strb=%b aluop=%b cnt=%0d want %0d %b cnt=%0d",
                 i, state, strobes(), alu_op, instr_count, es[i], ex[i], ec[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store_halt();
    logic [5:0] op [6] = '{OP_ST, OP_ST, OP_ST, OP_ST, OP_HALT, OP_HALT};
    logic [2:0] es [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
    logic [9:0] ex [6] = '{SB_FETCH, SB_NONE, SB_EXIMM, SB_MEMWR, SB_FETCH, SB_NONE};
    logic [1:0] ec [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    opcode = OP_ST;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'b1; opcode = op[i]; #1;
      n_tests++;
      if (state !== es[i] || strobes() !== ex[i] || instr_count !== ec[i] || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL store_halt cyc%0d: state=%0d strb=%b cnt=%0d halt=%b want %0d %b cnt=%0d halt=0",
                 i, state, strobes(), instr_count, halted, es[i], ex[i], ec[i]);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0]; #1;
      n_tests++;
      if (state !== 3'd5 || strobes() !== SB_NONE || alu_op !== 6'd0 || halted !== 1'b1 ||
          bus_error !== 1'b0 || instr_count !== 2'd1) begin
        n_fail++;
        $display("FAIL halted_hold cyc%0d: state=%0d strb=%b halt=%b berr=%b cnt=%0d want 5 0 1 0 1",
                 i, state, strobes(), halted, bus_error, instr_count);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    opcode = OP_ALU;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b0; #1;
      n_tests++;
      if (state !== 3'd0 || strobes() !== SB_FWAIT || bus_error !== 1'b0 || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait cyc%0d: state=%0d strb=%b berr=%b halt=%b want 0 %b 0 0",
                 i, state, strobes(), bus_error, halted, SB_FWAIT);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1; #1;
      n_tests++;
      if (state !== 3'd5 || strobes() !== SB_NONE || bus_error !== 1'b1 || halted !== 1'b1 ||
          instr_count !== 2'd0) begin
        n_fail++;
        $display("FAIL timeout_halt cyc%0d: state=%0d strb=%b berr=%b halt=%b cnt=%0d want 5 0 1 1 0",
                 i, state, strobes(), bus_error, halted, instr_count);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic       rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] es [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [9:0] ex [4] = '{SB_FETCH, SB_NONE, SB_EXIMM, SB_MEMRD};
    opcode = OP_LD;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem_ready = rd[i]; #1;
      n_tests++;
      if (state !== es[i] || strobes() !== ex[i]) begin
        n_fail++;
        $display("FAIL rstmid_pre cyc%0d: state=%0d strb=%b want %0d %b", i, state, strobes(), es[i], ex[i]);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1;
    rst_n = 1'b0; #1;
    n_tests++;
    if (state !== 3'd0 || strobes() !== SB_NONE || alu_op !== 6'd0 || instr_count !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_abort: state=%0d strb=%b cnt=%0d want 0 0 0", state, strobes(), instr_count);
    end
    mem_ready = 1'b1;
    @(negedge clk); #1;
    n_tests++;
    if (state !== 3'd0 || strobes() !== SB_NONE || instr_count !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_held: state=%0d strb=%b cnt=%0d want 0 0 0", state, strobes(), instr_count);
    end
    rst_n = 1'b1; #1;
    n_tests++;
    if (state !== 3'd0 || strobes() !== SB_FETCH || instr_count !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_refetch: state=%0d strb=%b cnt=%0d want 0 %b 0", state, strobes(), instr_count, SB_FETCH);
    end
    @(negedge clk); #1;
    n_tests++;
    if (state !== 3'd1) begin
      n_fail++;
      $display("FAIL rstmid_decode: state=%0d want 1", state);
    end
  endtask

  task automatic test_count_wrap();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    opcode = 6'b000000;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 3; j++) begin
        mem_ready = 1'b1; #1;
        n_tests++;
        if (state !== 3'(j)) begin
          n_fail++;
          $display("FAIL nop%0d state cyc%0d: got %0d want %0d", k, j, state, j);
        end
        @(negedge clk);
      end
      #1;
      n_tests++;
      if (instr_count !== exp_cnt[k]) begin
        n_fail++;
        $display("FAIL count_wrap nop%0d: got %0d want %0d", k, instr_count, exp_cnt[k]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_jump_illegal();
    test_store_halt();
    test_timeout();
    test_reset();
    test_reset_mid();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
